// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT stages: Q-format unity, clog2 helper,
// complex word type and the per-stage control state.
package fft_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } sdf_state_e;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx16_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Unity in Q1.(width-2): 2^(width-2)
  function automatic int q_one(input int width);
    return 1 << (width - 2);
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Enable-gated complex shift register; head is the oldest entry.
module sdf_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] din_re,
  input  logic signed [WIDTH-1:0] din_im,
  output logic signed [WIDTH-1:0] head_re,
  output logic signed [WIDTH-1:0] head_im
);

  logic signed [WIDTH-1:0] re_q [DEPTH];
  logic signed [WIDTH-1:0] im_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      re_q[DEPTH-1] <= din_re;
      im_q[DEPTH-1] <= din_im;
      for (int i = 0; i < DEPTH - 1; i++) begin
        re_q[i] <= re_q[i+1];
        im_q[i] <= im_q[i+1];
      end
    end
  end

  assign head_re = re_q[0];
  assign head_im = im_q[0];

endmodule

// File: rtl/sdf_dif_stage.sv
// Radix-2 SDF decimation-in-frequency stage: butterfly first, twiddle multiply
// second, one registered cycle from accepted input to output.
module sdf_dif_stage
  import fft_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int DELAY  = 8,
  localparam int ADDR_W = (DELAY > 1) ? clog2(DELAY) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic [ADDR_W-1:0]       tw_addr,
  input  logic signed [WIDTH-1:0] tw_re,
  input  logic signed [WIDTH-1:0] tw_im,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int CNT_W = clog2(2 * DELAY);
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(q_one(WIDTH));

  // (a +/- b) >>> 1 at WIDTH+1 bits always fits WIDTH, so no saturation
  function automatic logic signed [WIDTH-1:0] half_add(
    input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] t;
    t = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    return WIDTH'(t >>> 1);
  endfunction

  function automatic logic signed [WIDTH-1:0] half_sub(
    input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] t;
    t = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    return WIDTH'(t >>> 1);
  endfunction

  function automatic logic signed [2*WIDTH:0] sx(input logic signed [WIDTH-1:0] v);
    return {{(WIDTH+1){v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [WIDTH-1:0] q_scale(input logic signed [2*WIDTH:0] p);
    return WIDTH'(p >>> (WIDTH - 2));
  endfunction

  logic [CNT_W-1:0]        cnt;
  sdf_state_e              state;
  logic                    phase;
  logic signed [WIDTH-1:0] head_re, head_im;
  logic signed [WIDTH-1:0] dl_re, dl_im;
  logic signed [WIDTH-1:0] a_re, a_im, c_re, c_im;
  logic signed [2*WIDTH:0] acc_re, acc_im;
  logic                    vld_p1;
  logic signed [WIDTH-1:0] re_p1, im_p1;

  assign phase = cnt[CNT_W-1];

  if (DELAY > 1) begin : g_addr
    assign tw_addr = cnt[CNT_W-2:0];
  end else begin : g_addr_one
    assign tw_addr = 1'b0;
  end

  sdf_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DELAY)
  ) u_delay (
    .clk     (clk),
    .en      (in_valid & ~rst),
    .din_re  (dl_re),
    .din_im  (dl_im),
    .head_re (head_re),
    .head_im (head_im)
  );

  // Phase 0 rotates the stored difference; phase 1 emits the sum at unity gain
  always_comb begin
    dl_re = in_re;
    dl_im = in_im;
    a_re  = head_re;
    a_im  = head_im;
    c_re  = tw_re;
    c_im  = tw_im;
    if (phase) begin
      dl_re = half_sub(head_re, in_re);
      dl_im = half_sub(head_im, in_im);
      a_re  = half_add(head_re, in_re);
      a_im  = half_add(head_im, in_im);
      c_re  = ONE;
      c_im  = '0;
    end
    acc_re = sx(a_re) * sx(c_re) - sx(a_im) * sx(c_im);
    acc_im = sx(a_re) * sx(c_im) + sx(a_im) * sx(c_re);
  end

  // Stage p1: registered output and control
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      state  <= PRIME;
      vld_p1 <= 1'b0;
      re_p1  <= '0;
      im_p1  <= '0;
    end else begin
      vld_p1 <= in_valid && (state == RUN);
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        if (state == PRIME && cnt == CNT_W'(DELAY - 1)) state <= RUN;
        if (state == RUN) begin
          re_p1 <= q_scale(acc_re);
          im_p1 <= q_scale(acc_im);
        end
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_re    = re_p1;
  assign out_im    = im_p1;

endmodule

// File: tb/tb_sdf_dif_stage.sv
// Directed and randomised checks of sdf_dif_stage (WIDTH=16, DELAY=4) against
// a queue-based behavioural model with an exact W8 twiddle ROM.
module tb_sdf_dif_stage;

  localparam int WIDTH = 16;
  localparam int DELAY = 4;
  localparam int AW    = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_re, in_im;
  logic [AW-1:0]           tw_addr;
  logic signed [WIDTH-1:0] tw_re, tw_im;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_re, out_im;

  typedef struct {
    longint re;
    longint im;
  } exp_t;

  exp_t   sb[$];
  longint dl_re[$];
  longint dl_im[$];
  int     m_cnt;
  bit     m_run;
  longint last_re, last_im;
  int     total = 0;
  int     bad   = 0;

  always #5 clk = ~clk;

  function automatic longint tw_val(input int k, input bit im);
    real ang;
    ang = 2.0 * 3.14159265358979 * real'(k) / real'(2 * DELAY);
    if (im) return longint'(-16384.0 * $sin(ang));
    return longint'(16384.0 * $cos(ang));
  endfunction

  assign tw_re = 16'(tw_val(int'(tw_addr), 1'b0));
  assign tw_im = 16'(tw_val(int'(tw_addr), 1'b1));

  sdf_dif_stage #(
    .WIDTH (WIDTH),
    .DELAY (DELAY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_im     (in_im),
    .tw_addr   (tw_addr),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  function automatic longint fdiv(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset(input bit v);
    rst      = 1'b1;
    in_valid = v;
    in_re    = 16'sd1234;
    in_im    = -16'sd77;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    m_cnt    = 0;
    m_run    = 0;
    last_re  = 0;
    last_im  = 0;
    sb.delete();
    chk("rst_valid", out_valid, 0);
    chk("rst_re", out_re, last_re);
    chk("rst_im", out_im, last_im);
  endtask

  task automatic drive(input bit v, input longint re, input longint im);
    bit     exp_v, ph;
    int     k;
    exp_t   e;
    longint hr, hi, ar, ai, cr, ci;
    in_valid = v;
    in_re    = 16'(re);
    in_im    = 16'(im);
    exp_v    = 0;
    k        = m_cnt % DELAY;
    ph       = (m_cnt >= DELAY);
    chk("tw_addr", tw_addr, k);
    if (v) begin
      hr = dl_re.pop_front();
      hi = dl_im.pop_front();
      if (!ph) begin
        dl_re.push_back(re);
        dl_im.push_back(im);
        ar = hr;
        ai = hi;
        cr = tw_val(k, 1'b0);
        ci = tw_val(k, 1'b1);
      end else begin
        dl_re.push_back(fdiv(hr - re, 2));
        dl_im.push_back(fdiv(hi - im, 2));
        ar = fdiv(hr + re, 2);
        ai = fdiv(hi + im, 2);
        cr = 16384;
        ci = 0;
      end
      if (m_run) begin
        e.re = wrap16(fdiv(ar * cr - ai * ci, 16384));
        e.im = wrap16(fdiv(ar * ci + ai * cr, 16384));
        sb.push_back(e);
        exp_v = 1;
      end else if (m_cnt == DELAY - 1) begin
        m_run = 1;
      end
      m_cnt = (m_cnt + 1) % (2 * DELAY);
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, exp_v);
    if (exp_v) begin
      e = sb.pop_front();
      chk("out_re", out_re, e.re);
      chk("out_im", out_im, e.im);
      last_re = e.re;
      last_im = e.im;
    end else begin
      chk("hold_re", out_re, last_re);
      chk("hold_im", out_im, last_im);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    for (int i = 0; i < DELAY; i++) begin
      dl_re.push_back(0);
      dl_im.push_back(0);
    end

    // Impulse
    do_reset(1'b0);
    drive(1, 8000, 0);
    for (int i = 0; i < 11; i++) drive(1, 0, 0);

    // DC
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) drive(1, 1000, 0);

    // Step
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) drive(1, 1000, 0);
    for (int i = 0; i < 4; i++) drive(1, -1000, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0);

    // Impulse with a stall every other cycle; stalled data must be ignored
    do_reset(1'b0);
    drive(1, 8000, 0);
    drive(0, 555, -555);
    for (int i = 0; i < 11; i++) begin
      drive(1, 0, 0);
      drive(0, -4321, 999);
    end

    // Extremes of the butterfly range
    do_reset(1'b0);
    drive(1, 32767, -32768);
    drive(1, -32768, 32767);
    drive(1, 32767, 0);
    drive(1, -32768, 0);
    drive(1, 32767, -32768);
    drive(1, -32768, 32767);
    drive(1, -32768, 0);
    drive(1, 32767, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0);

    // Random complex data with random stalls
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 3) != 0,
            longint'(int'($urandom_range(0, 65535))) - 32768,
            longint'(int'($urandom_range(0, 65535))) - 32768);
    end

    // Reset mid-frame, asserted together with a valid input
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) drive(1, 100 * (i + 1), -50 * i);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) drive(1, 2000 - 300 * i, 70 * i);
    for (int i = 0; i < 4; i++) drive(1, 123 * i, -321);
    for (int i = 0; i < 2; i++) drive(1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
